hack_rom_loader: RTL and testbench

HACK_ROM_LOADER -- requirements
Module: hack_rom_loader

---
 rtl/hack_rom_loader.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_hack_rom_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_rom_loader.sv
// ---------------------------------------------------------------------------
// hack_rom_loader
//
// Purpose:
//   Loads a program into the HACK instruction ROM from an 8N1 serial stream
//   sent by the AVR. While load_req is high, byte pairs (high byte first)
//   are assembled into 16-bit words. Each word is written to consecutive
//   ROM addresses starting at 0. The CPU is held in reset for the whole
//   load session.
//
// Optional feature:
//   ROM_LOADER_CKSUM_EN - when defined, cksum accumulates the modulo-2^16
//   sum of every written word. When undefined, cksum is tied to 0 and no
//   adder is built.
//
// Parameters:
//   CLK_PER_BIT - clk cycles per serial bit (default 100 = 50 MHz/500 kbaud)
//   ADDR_W      - ROM address width
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   load_req   in   load-mode request level (asynchronous, synchronised here)
//   rx         in   8N1 serial data, idle high (asynchronous)
//   rom_addr   out  ROM write address
//   rom_data   out  ROM write data (holds its value between writes)
//   rom_we     out  one-cycle ROM write strobe
//   cpu_hold   out  keeps the HACK CPU in reset while loading
//   busy       out  loader not idle, or receiver mid-frame
//   word_count out  words written in the current/last load (saturating)
//   frame_err  out  sticky stop-bit error, cleared when a load starts
//   cksum      out  modulo-2^16 sum of the written words
// ---------------------------------------------------------------------------
module hack_rom_loader #(
    parameter int CLK_PER_BIT = 100,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              rom_we,
    output logic              cpu_hold,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              frame_err,
    output logic [15:0]       cksum
);

    localparam int                CNT_W    = $clog2(CLK_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   WC_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_HI,
        LOAD_LO,
        DONE
    } ld_state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        rx_sync_q, rx_sync_d;
    logic [1:0]        ld_sync_q, ld_sync_d;
    logic              ld_prev_q, ld_prev_d;

    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shreg_q, shreg_d;

    ld_state_t         ld_state_q, ld_state_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]       rom_data_q, rom_data_d;
    logic              rom_we_q, rom_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              frame_err_q, frame_err_d;
    logic              start_pend_q, start_pend_d;

    logic              rx_s;
    logic              ld_s;
    logic              load_rise;
    logic              load_start;
    logic              rom_full;
    logic              byte_valid;
    logic              frame_set;

    assign rx_s       = rx_sync_q[1];
    assign ld_s       = ld_sync_q[1];
    assign load_rise  = ld_s & ~ld_prev_q;
    // A rise seen during DONE is remembered and acted on once back in IDLE.
    assign load_start = (ld_state_q == IDLE) && (load_rise || start_pend_q);
    assign rom_full   = word_count_q[ADDR_W];

    // -----------------------------------------------------------------------
    // Synchronisers (rx idles high, load_req idles low)
    // -----------------------------------------------------------------------
    always_comb begin
        rx_sync_d = {rx_sync_q[0], rx};
        ld_sync_d = {ld_sync_q[0], load_req};
        ld_prev_d = ld_s;
    end

    // -----------------------------------------------------------------------
    // 8N1 receiver. byte_valid is asserted in the stop-sample cycle, with the
    // assembled byte in shreg_q.
    // -----------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        byte_valid = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Entry to RX_IDLE only happens with rx high, so a low level
                // here is always a fresh falling edge.
                if (!rx_s) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d      = '0;
                    bit_idx_d  = 3'd0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_valid = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        rx_state_d = RX_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RX_WAIT: begin
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Loader
    // -----------------------------------------------------------------------
    always_comb begin
        ld_state_d   = ld_state_q;
        hi_d         = hi_q;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        rom_we_d     = 1'b0;
        word_count_d = word_count_q;
        frame_err_d  = frame_err_q;
        start_pend_d = 1'b0;

        // Address/count advance in the cycle after the strobe. The address
        // sticks at the top location; the count saturates at 2^ADDR_W.
        if (rom_we_q) begin
            if (!rom_full) begin
                word_count_d = word_count_q + WC_ONE;
            end
            if (rom_addr_q != ADDR_MAX) begin
                rom_addr_d = rom_addr_q + ADDR_ONE;
            end
        end

        case (ld_state_q)
            IDLE: begin
                if (load_start) begin
                    ld_state_d   = LOAD_HI;
                    rom_addr_d   = '0;
                    word_count_d = '0;
                    frame_err_d  = 1'b0;
                end
            end
            LOAD_HI: begin
                if (!ld_s) begin
                    ld_state_d = DONE;
                end else if (byte_valid) begin
                    hi_d       = shreg_q;
                    ld_state_d = LOAD_LO;
                end
            end
            LOAD_LO: begin
                // A word finishing as load_req drops is still written.
                if (byte_valid) begin
                    if (!rom_full) begin
                        rom_we_d   = 1'b1;
                        rom_data_d = {hi_q, shreg_q};
                    end
                    ld_state_d = LOAD_HI;
                end
                if (!ld_s) begin
                    ld_state_d = DONE;
                end
            end
            DONE: begin
                ld_state_d   = IDLE;
                start_pend_d = load_rise;
            end
            default: ld_state_d = IDLE;
        endcase

        if (frame_set) begin
            frame_err_d = 1'b1;
        end

        cpu_hold_d = (ld_state_d != IDLE);
        busy_d     = (ld_state_d != IDLE) || (rx_state_d != RX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync_q    <= 2'b11;
            ld_sync_q    <= 2'b00;
            ld_prev_q    <= 1'b0;
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shreg_q      <= 8'h00;
            ld_state_q   <= IDLE;
            hi_q         <= 8'h00;
            rom_addr_q   <= '0;
            rom_data_q   <= 16'h0000;
            rom_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            rx_sync_q    <= rx_sync_d;
            ld_sync_q    <= ld_sync_d;
            ld_prev_q    <= ld_prev_d;
            rx_state_q   <= rx_state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            ld_state_q   <= ld_state_d;
            hi_q         <= hi_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            rom_we_q     <= rom_we_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            word_count_q <= word_count_d;
            frame_err_q  <= frame_err_d;
            start_pend_q <= start_pend_d;
        end
    end

    // -----------------------------------------------------------------------
    // Checksum
    // -----------------------------------------------------------------------
`ifdef ROM_LOADER_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (load_start) begin
            cksum_d = 16'h0000;
        end else if (rom_we_q) begin
            cksum_d = cksum_q + rom_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum_q <= 16'h0000;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 16'h0000;
`endif

    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign rom_we     = rom_we_q;
    assign cpu_hold   = cpu_hold_q;
    assign busy       = busy_q;
    assign word_count = word_count_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_hack_rom_loader
//
// Directed bench for hack_rom_loader with CLK_PER_BIT=8, ADDR_W=4. Serial
// frames are driven on rx; every rom_we pulse is captured by a monitor into
// queues and checked against hand-computed words afterwards. Expected
// checksums follow ROM_LOADER_CKSUM_EN (0 when the feature is not built).
// ---------------------------------------------------------------------------
module tb_hack_rom_loader;

    localparam int CPB    = 8;
    localparam int ADDR_W = 4;
`ifdef ROM_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              load_req;
    logic              rx;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              rom_we;
    logic              cpu_hold;
    logic              busy;
    logic [ADDR_W:0]   word_count;
    logic              frame_err;
    logic [15:0]       cksum;

    int n_checks = 0;
    int n_pass   = 0;

    logic [ADDR_W-1:0] wr_addr[$];
    logic [15:0]       wr_data[$];

    hack_rom_loader #(
        .CLK_PER_BIT(CPB),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .rx        (rx),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_we    (rom_we),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .word_count(word_count),
        .frame_err (frame_err),
        .cksum     (cksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture each write strobe mid-cycle.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            wr_addr.push_back(rom_addr);
            wr_data.push_back(rom_data);
            $display("write addr=%0d data=0x%04h", rom_addr, rom_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame, LSB first, chosen stop level, then a short idle gap.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop;
        cycles(CPB);
        rx = 1'b1;
        cycles(4);
        $display("sent byte 0x%02h stop=%0b", b, stop);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic start_load();
        load_req = 1'b1;
        cycles(6);
    endtask

    task automatic end_load();
        load_req = 1'b0;
        cycles(8);
    endtask

    logic [15:0] exp_sum;

    initial begin
        rst      = 1'b1;
        load_req = 1'b0;
        rx       = 1'b1;
        cycles(3);

        // Reset state
        check("rst_rom_addr",   32'(rom_addr),   32'h0);
        check("rst_rom_data",   32'(rom_data),   32'h0);
        check("rst_rom_we",     32'(rom_we),     32'h0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_cksum",      32'(cksum),      32'h0);
        rst = 1'b0;
        cycles(3);

        // Basic two-word load
        clear_writes();
        start_load();
        check("load_cpu_hold", 32'(cpu_hold), 32'h1);
        check("load_busy",     32'(busy),     32'h1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        check("basic_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("basic_addr0", 32'(wr_addr[0]), 32'd0);
            check("basic_data0", 32'(wr_data[0]), 32'h1234);
            check("basic_addr1", 32'(wr_addr[1]), 32'd1);
            check("basic_data1", 32'(wr_data[1]), 32'hABCD);
        end
        check("basic_wc",       32'(word_count), 32'd2);
        check("basic_rom_addr", 32'(rom_addr),   32'd2);
        check("basic_cksum",    32'(cksum),      CK_EN ? 32'hBE01 : 32'h0);
        check("basic_hold_dat", 32'(rom_data),   32'hABCD);
        end_load();
        check("done_cpu_hold", 32'(cpu_hold),   32'h0);
        check("done_busy",     32'(busy),       32'h0);
        check("done_wc_held",  32'(word_count), 32'd2);
        check("done_ck_held",  32'(cksum),      CK_EN ? 32'hBE01 : 32'h0);

        // False start, then framing error, then a good word
        clear_writes();
        start_load();
        check("new_load_wc_clr", 32'(word_count), 32'd0);
        check("new_load_ck_clr", 32'(cksum),      32'h0);
        rx = 1'b0;
        cycles(2);
        rx = 1'b1;
        cycles(100);
        check("glitch_nwr",   32'(wr_addr.size()), 32'd0);
        check("glitch_ferr",  32'(frame_err),      32'h0);
        send_byte(8'h55, 1'b0);
        check("ferr_set", 32'(frame_err),      32'h1);
        check("ferr_nwr", 32'(wr_addr.size()), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        check("ferr_next_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("ferr_next_addr", 32'(wr_addr[0]), 32'd0);
            check("ferr_next_data", 32'(wr_data[0]), 32'h0001);
        end
        check("ferr_sticky", 32'(frame_err), 32'h1);
        end_load();

        // Overflow: 17 words into a 16-entry ROM
        clear_writes();
        start_load();
        check("ovf_ferr_clr", 32'(frame_err), 32'h0);
        exp_sum = 16'h0000;
        for (int w = 0; w < 17; w++) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'(w), 1'b1);
            if (w < 16) exp_sum = exp_sum + 16'(w);
        end
        check("ovf_nwr", 32'(wr_addr.size()), 32'd16);
        for (int w = 0; w < 16; w++) begin
            if (w < wr_addr.size()) begin
                check($sformatf("ovf_addr%0d", w), 32'(wr_addr[w]), 32'(w));
                check($sformatf("ovf_data%0d", w), 32'(wr_data[w]), 32'(w));
            end
        end
        check("ovf_wc",       32'(word_count), 32'd16);
        check("ovf_rom_addr", 32'(rom_addr),   32'd15);
        check("ovf_cksum",    32'(cksum),      CK_EN ? 32'(exp_sum) : 32'h0);
        end_load();

        // Partial high byte discarded when load_req drops
        clear_writes();
        start_load();
        send_byte(8'h77, 1'b1);
        end_load();
        start_load();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        check("part_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("part_addr", 32'(wr_addr[0]), 32'd0);
            check("part_data", 32'(wr_data[0]), 32'h0102);
        end
        check("part_wc", 32'(word_count), 32'd1);

        // Reset during bit 4 of a low byte
        clear_writes();
        send_byte(8'h00, 1'b1);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(i & 1);
            cycles(CPB);
        end
        rx = 1'b1;
        cycles(4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rom_we",   32'(rom_we),     32'h0);
        check("arst_cpu_hold", 32'(cpu_hold),   32'h0);
        check("arst_busy",     32'(busy),       32'h0);
        check("arst_rom_addr", 32'(rom_addr),   32'h0);
        check("arst_rom_data", 32'(rom_data),   32'h0);
        check("arst_wc",       32'(word_count), 32'h0);
        check("arst_cksum",    32'(cksum),      32'h0);
        load_req = 1'b0;
        cycles(5);
        rst = 1'b0;
        cycles(100);
        check("arst_nwr",       32'(wr_addr.size()), 32'd0);
        check("arst_hold_post", 32'(cpu_hold),       32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
